// File: rtl/bob_pkg.sv
// Shared types and constants for the branch order buffer.
package bob_pkg;

  localparam int PC_W  = 64;
  localparam int TYP_W = 2;

  localparam logic [TYP_W-1:0] BRTYP_COND   = 2'b00;
  localparam logic [TYP_W-1:0] BRTYP_DIRECT = 2'b01;
  localparam logic [TYP_W-1:0] BRTYP_INDIR  = 2'b10;
  localparam logic [TYP_W-1:0] BRTYP_RET    = 2'b11;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [TYP_W-1:0] typ;
    logic             pdir;
    logic [PC_W-1:0]  ptar;
    logic             dir;
    logic [PC_W-1:0]  tar;
    logic             valid;
    logic             resolved;
  } bob_entry_t;

endpackage

// File: rtl/bob_mispred_chk.sv
// Combinational mispredict check and redirect target for the committing entry.
module bob_mispred_chk
  import bob_pkg::*;
(
  input  bob_entry_t       ent,
  output logic             mispred,
  output logic [PC_W-1:0]  redirect_pc
);

  logic raw_s;

  // Per-type mispredict rule; only meaningful for a live, resolved entry
  always_comb begin
    raw_s = 1'b0;
    case (ent.typ)
      BRTYP_COND:             raw_s = (ent.dir != ent.pdir) | (ent.dir & (ent.tar != ent.ptar));
      BRTYP_INDIR, BRTYP_RET: raw_s = (ent.tar != ent.ptar);
      BRTYP_DIRECT:           raw_s = 1'b0;
      default:                raw_s = 1'b0;
    endcase
    mispred     = ent.valid & ent.resolved & raw_s;
    redirect_pc = ent.dir ? ent.tar : (ent.pc + 64'd4);
  end

endmodule

// File: rtl/bob.sv
// Branch order buffer: in-order circular queue, out-of-order resolve, in-order retire.
// Optional feature: define BOB_STATS_EN to add saturating commit/mispredict counters.
module bob
  import bob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_vld_i,
  input  logic [63:0]      alloc_brpc_i,
  input  logic [1:0]       alloc_brtyp_i,
  input  logic             alloc_pdir_i,
  input  logic [63:0]      alloc_ptar_i,
  output logic             alloc_rdy_o,
  output logic [IDX_W-1:0] alloc_tag_o,
  input  logic             rslv_vld_i,
  input  logic [IDX_W-1:0] rslv_tag_i,
  input  logic             rslv_dir_i,
  input  logic [63:0]      rslv_tar_i,
  input  logic             commit_br_i,
  output logic             brcond_vld_rt_o,
  output logic             brindir_vld_rt_o,
  output logic             brdir_rt_o,
  output logic [63:0]      brtar_rt_o,
  output logic [63:0]      brpc_rt_o,
  output logic             flush_o,
  output logic [63:0]      redirect_pc_o
`ifdef BOB_STATS_EN
  ,
  output logic [31:0]      stat_ret_o,
  output logic [31:0]      stat_mis_o
`endif
);

  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);

  logic [PC_W-1:0]  pc_r   [DEPTH];
  logic [TYP_W-1:0] typ_r  [DEPTH];
  logic             pdir_r [DEPTH];
  logic [PC_W-1:0]  ptar_r [DEPTH];
  logic             dir_r  [DEPTH];
  logic [PC_W-1:0]  tar_r  [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] resolved_r;

  logic [IDX_W-1:0] head_r;
  logic [IDX_W-1:0] tail_r;
  logic [IDX_W:0]   count_r;

  logic             alloc_rdy_s;
  logic             alloc_fire_s;
  logic             rslv_fire_s;
  logic             commit_fire_s;
  logic             flush_fire_s;
  logic             mispred_s;
  logic [PC_W-1:0]  redirect_s;
  bob_entry_t       head_ent_s;

  logic             brcond_vld_r;
  logic             brindir_vld_r;
  logic             brdir_r;
  logic [PC_W-1:0]  brtar_r;
  logic [PC_W-1:0]  brpc_r;
  logic             flush_r;
  logic [PC_W-1:0]  redirect_pc_r;

  // Handshake qualification; all decisions use pre-edge state
  always_comb begin
    head_ent_s.pc       = pc_r[head_r];
    head_ent_s.typ      = typ_r[head_r];
    head_ent_s.pdir     = pdir_r[head_r];
    head_ent_s.ptar     = ptar_r[head_r];
    head_ent_s.dir      = dir_r[head_r];
    head_ent_s.tar      = tar_r[head_r];
    head_ent_s.valid    = valid_r[head_r];
    head_ent_s.resolved = resolved_r[head_r];
    alloc_rdy_s   = (count_r != FULL_CNT);
    commit_fire_s = commit_br_i & valid_r[head_r] & resolved_r[head_r];
    flush_fire_s  = commit_fire_s & mispred_s;
    alloc_fire_s  = alloc_vld_i & alloc_rdy_s & ~flush_fire_s;
    rslv_fire_s   = rslv_vld_i & valid_r[rslv_tag_i] & ~resolved_r[rslv_tag_i];
  end

  bob_mispred_chk u_mispred_chk (
    .ent         (head_ent_s),
    .mispred     (mispred_s),
    .redirect_pc (redirect_s)
  );

  // Entry payload storage; alloc slot is never live, so it cannot collide with a resolve
  always_ff @(posedge clock) begin
    if (alloc_fire_s) begin
      pc_r[tail_r]   <= alloc_brpc_i;
      typ_r[tail_r]  <= alloc_brtyp_i;
      pdir_r[tail_r] <= alloc_pdir_i;
      ptar_r[tail_r] <= alloc_ptar_i;
      dir_r[tail_r]  <= 1'b1;
      tar_r[tail_r]  <= alloc_ptar_i;
    end
    if (rslv_fire_s) begin
      dir_r[rslv_tag_i] <= rslv_dir_i;
      tar_r[rslv_tag_i] <= rslv_tar_i;
    end
  end

  // Pointers, occupancy and per-entry valid/resolved flags
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      valid_r    <= '0;
      resolved_r <= '0;
    end else if (flush_fire_s) begin
      head_r     <= head_r + PTR_ONE;
      tail_r     <= head_r + PTR_ONE;
      count_r    <= '0;
      valid_r    <= '0;
      resolved_r <= '0;
    end else begin
      if (rslv_fire_s) begin
        resolved_r[rslv_tag_i] <= 1'b1;
      end
      if (commit_fire_s) begin
        valid_r[head_r]    <= 1'b0;
        resolved_r[head_r] <= 1'b0;
        head_r             <= head_r + PTR_ONE;
      end
      if (alloc_fire_s) begin
        valid_r[tail_r]    <= 1'b1;
        resolved_r[tail_r] <= (alloc_brtyp_i == BRTYP_DIRECT);
        tail_r             <= tail_r + PTR_ONE;
      end
      case ({alloc_fire_s, commit_fire_s})
        2'b10:   count_r <= count_r + (IDX_W+1)'(1);
        2'b01:   count_r <= count_r - (IDX_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered retire port and redirect; payloads hold between pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      brcond_vld_r  <= 1'b0;
      brindir_vld_r <= 1'b0;
      brdir_r       <= 1'b0;
      brtar_r       <= '0;
      brpc_r        <= '0;
      flush_r       <= 1'b0;
      redirect_pc_r <= '0;
    end else begin
      brcond_vld_r  <= commit_fire_s & (head_ent_s.typ == BRTYP_COND);
      brindir_vld_r <= commit_fire_s & head_ent_s.typ[1];
      flush_r       <= flush_fire_s;
      if (commit_fire_s) begin
        brdir_r <= head_ent_s.dir;
        brtar_r <= head_ent_s.tar;
        brpc_r  <= head_ent_s.pc;
      end
      if (flush_fire_s) begin
        redirect_pc_r <= redirect_s;
      end
    end
  end

`ifdef BOB_STATS_EN
  logic [31:0] stat_ret_r;
  logic [31:0] stat_mis_r;

  // Saturating retire and mispredict counters
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_ret_r <= 32'd0;
      stat_mis_r <= 32'd0;
    end else begin
      if (commit_fire_s && (stat_ret_r != 32'hFFFF_FFFF)) begin
        stat_ret_r <= stat_ret_r + 32'd1;
      end
      if (flush_fire_s && (stat_mis_r != 32'hFFFF_FFFF)) begin
        stat_mis_r <= stat_mis_r + 32'd1;
      end
    end
  end

  assign stat_ret_o = stat_ret_r;
  assign stat_mis_o = stat_mis_r;
`endif

  assign alloc_rdy_o      = alloc_rdy_s;
  assign alloc_tag_o      = tail_r;
  assign brcond_vld_rt_o  = brcond_vld_r;
  assign brindir_vld_rt_o = brindir_vld_r;
  assign brdir_rt_o       = brdir_r;
  assign brtar_rt_o       = brtar_r;
  assign brpc_rt_o        = brpc_r;
  assign flush_o          = flush_r;
  assign redirect_pc_o    = redirect_pc_r;

endmodule

// File: tb/tb_bob.sv
// Directed self-checking bench for the branch order buffer (default build).
module tb_bob;

  logic        clock = 1'b0;
  logic        reset;
  logic        alloc_vld_i;
  logic [63:0] alloc_brpc_i;
  logic [1:0]  alloc_brtyp_i;
  logic        alloc_pdir_i;
  logic [63:0] alloc_ptar_i;
  logic        alloc_rdy_o;
  logic [3:0]  alloc_tag_o;
  logic        rslv_vld_i;
  logic [3:0]  rslv_tag_i;
  logic        rslv_dir_i;
  logic [63:0] rslv_tar_i;
  logic        commit_br_i;
  logic        brcond_vld_rt_o;
  logic        brindir_vld_rt_o;
  logic        brdir_rt_o;
  logic [63:0] brtar_rt_o;
  logic [63:0] brpc_rt_o;
  logic        flush_o;
  logic [63:0] redirect_pc_o;
`ifdef BOB_STATS_EN
  logic [31:0] stat_ret_o;
  logic [31:0] stat_mis_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bob #(.DEPTH(16), .IDX_W(4)) dut (
    .clock(clock), .reset(reset),
    .alloc_vld_i(alloc_vld_i), .alloc_brpc_i(alloc_brpc_i), .alloc_brtyp_i(alloc_brtyp_i),
    .alloc_pdir_i(alloc_pdir_i), .alloc_ptar_i(alloc_ptar_i),
    .alloc_rdy_o(alloc_rdy_o), .alloc_tag_o(alloc_tag_o),
    .rslv_vld_i(rslv_vld_i), .rslv_tag_i(rslv_tag_i), .rslv_dir_i(rslv_dir_i), .rslv_tar_i(rslv_tar_i),
    .commit_br_i(commit_br_i),
    .brcond_vld_rt_o(brcond_vld_rt_o), .brindir_vld_rt_o(brindir_vld_rt_o),
    .brdir_rt_o(brdir_rt_o), .brtar_rt_o(brtar_rt_o), .brpc_rt_o(brpc_rt_o),
    .flush_o(flush_o), .redirect_pc_o(redirect_pc_o)
`ifdef BOB_STATS_EN
    , .stat_ret_o(stat_ret_o), .stat_mis_o(stat_mis_o)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_alloc(input logic [63:0] pc, input logic [1:0] typ,
                          input logic pdir, input logic [63:0] ptar);
    alloc_vld_i = 1'b1; alloc_brpc_i = pc; alloc_brtyp_i = typ;
    alloc_pdir_i = pdir; alloc_ptar_i = ptar;
    tick();
    alloc_vld_i = 1'b0;
  endtask

  task automatic do_resolve(input logic [3:0] tag, input logic dir, input logic [63:0] tar);
    rslv_vld_i = 1'b1; rslv_tag_i = tag; rslv_dir_i = dir; rslv_tar_i = tar;
    tick();
    rslv_vld_i = 1'b0;
  endtask

  task automatic do_commit();
    commit_br_i = 1'b1;
    tick();
    commit_br_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({brcond_vld_rt_o, brindir_vld_rt_o, brdir_rt_o, flush_o} !== 4'b0000) begin
      $display("FAIL reset_flags got=%b exp=0000", {brcond_vld_rt_o, brindir_vld_rt_o, brdir_rt_o, flush_o});
      failures++;
    end
    checks++;
    if ({brtar_rt_o, brpc_rt_o, redirect_pc_o} !== 192'd0) begin
      $display("FAIL reset_data got=%h %h %h exp=0", brtar_rt_o, brpc_rt_o, redirect_pc_o);
      failures++;
    end
    checks++;
    if ({alloc_rdy_o, alloc_tag_o} !== 5'b1_0000) begin
      $display("FAIL reset_alloc got rdy=%b tag=%0d exp rdy=1 tag=0", alloc_rdy_o, alloc_tag_o);
      failures++;
    end
    reset = 1'b0;
  endtask

  task automatic test_cond_correct();
    checks++;
    if (alloc_tag_o !== 4'd0) begin
      $display("FAIL cc_tag got=%0d exp=0", alloc_tag_o); failures++;
    end
    do_alloc(64'h1000, 2'b00, 1'b0, 64'h0);
    do_resolve(4'd0, 1'b0, 64'h0);
    do_commit();
    checks++;
    if ({brcond_vld_rt_o, brindir_vld_rt_o, brdir_rt_o, flush_o} !== 4'b1000) begin
      $display("FAIL cc_retire got=%b exp=1000", {brcond_vld_rt_o, brindir_vld_rt_o, brdir_rt_o, flush_o});
      failures++;
    end
    checks++;
    if (brpc_rt_o !== 64'h1000) begin
      $display("FAIL cc_pc got=%h exp=1000", brpc_rt_o); failures++;
    end
    tick();
    checks++;
    if (brcond_vld_rt_o !== 1'b0 || brpc_rt_o !== 64'h1000) begin
      $display("FAIL cc_pulse got vld=%b pc=%h exp vld=0 pc=1000", brcond_vld_rt_o, brpc_rt_o);
      failures++;
    end
  endtask

  task automatic test_cond_mispred();
    do_alloc(64'h2000, 2'b00, 1'b0, 64'h0);
    do_resolve(4'd1, 1'b1, 64'h3000);
    do_commit();
    checks++;
    if ({brcond_vld_rt_o, brdir_rt_o, flush_o} !== 3'b111 || redirect_pc_o !== 64'h3000) begin
      $display("FAIL cm_flush got=%b redir=%h exp=111 redir=3000", {brcond_vld_rt_o, brdir_rt_o, flush_o}, redirect_pc_o);
      failures++;
    end
    checks++;
    if (dut.count_r !== 5'd0 || alloc_tag_o !== 4'd2) begin
      $display("FAIL cm_empty got cnt=%0d tag=%0d exp cnt=0 tag=2", dut.count_r, alloc_tag_o);
      failures++;
    end
    tick();
    checks++;
    if (flush_o !== 1'b0) begin
      $display("FAIL cm_pulse got=%b exp=0", flush_o); failures++;
    end
    // predicted taken, actually not taken: fall-through wraps past 2^64
    do_alloc(64'hFFFF_FFFF_FFFF_FFFC, 2'b00, 1'b1, 64'h5555);
    do_resolve(4'd2, 1'b0, 64'h0);
    do_commit();
    checks++;
    if (flush_o !== 1'b1 || redirect_pc_o !== 64'h0) begin
      $display("FAIL cm_wrap got flush=%b redir=%h exp flush=1 redir=0", flush_o, redirect_pc_o);
      failures++;
    end
  endtask

  task automatic test_indirect();
    do_alloc(64'h4000, 2'b10, 1'b1, 64'h5000);
    do_resolve(4'd3, 1'b1, 64'h5000);
    do_commit();
    checks++;
    if ({brcond_vld_rt_o, brindir_vld_rt_o, flush_o} !== 3'b010 || brtar_rt_o !== 64'h5000) begin
      $display("FAIL ind_ok got=%b tar=%h exp=010 tar=5000", {brcond_vld_rt_o, brindir_vld_rt_o, flush_o}, brtar_rt_o);
      failures++;
    end
    do_alloc(64'h4000, 2'b11, 1'b1, 64'h5000);
    do_resolve(4'd4, 1'b1, 64'h6000);
    do_commit();
    checks++;
    if ({brindir_vld_rt_o, flush_o} !== 2'b11 || redirect_pc_o !== 64'h6000) begin
      $display("FAIL ind_mis got=%b redir=%h exp=11 redir=6000", {brindir_vld_rt_o, flush_o}, redirect_pc_o);
      failures++;
    end
  endtask

  task automatic test_direct();
    do_alloc(64'hA000, 2'b01, 1'b1, 64'hB000);
    do_commit();
    checks++;
    if ({brcond_vld_rt_o, brindir_vld_rt_o, brdir_rt_o, flush_o} !== 4'b0010) begin
      $display("FAIL dir_flags got=%b exp=0010", {brcond_vld_rt_o, brindir_vld_rt_o, brdir_rt_o, flush_o});
      failures++;
    end
    checks++;
    if (brpc_rt_o !== 64'hA000 || brtar_rt_o !== 64'hB000 || dut.count_r !== 5'd0) begin
      $display("FAIL dir_pop got pc=%h tar=%h cnt=%0d exp pc=a000 tar=b000 cnt=0", brpc_rt_o, brtar_rt_o, dut.count_r);
      failures++;
    end
  endtask

  task automatic test_fill();
    logic [3:0]  et;
    logic [3:0]  rord [4];
    logic [63:0] epc;
    rord[0] = 4'd9; rord[1] = 4'd6; rord[2] = 4'd7; rord[3] = 4'd8;
    for (int i = 0; i < 16; i++) begin
      et = 4'(6 + i);
      checks++;
      if (alloc_tag_o !== et) begin
        $display("FAIL fill_tag%0d got=%0d exp=%0d", i, alloc_tag_o, et); failures++;
      end
      do_alloc(64'h8000 + 64'(i) * 64'h100, 2'b00, 1'b0, 64'h0);
    end
    checks++;
    if (alloc_rdy_o !== 1'b0 || dut.count_r !== 5'd16) begin
      $display("FAIL full got rdy=%b cnt=%0d exp rdy=0 cnt=16", alloc_rdy_o, dut.count_r); failures++;
    end
    do_alloc(64'hEEEE, 2'b00, 1'b0, 64'h0);
    checks++;
    if (alloc_tag_o !== 4'd6 || dut.count_r !== 5'd16) begin
      $display("FAIL drop got tag=%0d cnt=%0d exp tag=6 cnt=16", alloc_tag_o, dut.count_r); failures++;
    end
    for (int i = 0; i < 4; i++) do_resolve(rord[i], 1'b0, 64'h0);
    // first commit coincides with an alloc that must be refused while still full
    commit_br_i = 1'b1;
    alloc_vld_i = 1'b1; alloc_brpc_i = 64'hEEEE; alloc_brtyp_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      alloc_vld_i = 1'b0;
      epc = 64'h8000 + 64'(i) * 64'h100;
      checks++;
      if (brcond_vld_rt_o !== 1'b1 || brpc_rt_o !== epc) begin
        $display("FAIL fill_ret%0d got vld=%b pc=%h exp vld=1 pc=%h", i, brcond_vld_rt_o, brpc_rt_o, epc);
        failures++;
      end
      if (i == 0) begin
        checks++;
        if (dut.count_r !== 5'd15 || alloc_tag_o !== 4'd6) begin
          $display("FAIL full_alloc got cnt=%0d tag=%0d exp cnt=15 tag=6", dut.count_r, alloc_tag_o);
          failures++;
        end
      end
    end
    commit_br_i = 1'b0;
  endtask

  task automatic test_unresolved();
    commit_br_i = 1'b1;
    tick();
    checks++;
    if (brcond_vld_rt_o !== 1'b0 || dut.count_r !== 5'd12) begin
      $display("FAIL unres got vld=%b cnt=%0d exp vld=0 cnt=12", brcond_vld_rt_o, dut.count_r); failures++;
    end
    rslv_vld_i = 1'b1; rslv_tag_i = 4'd10; rslv_dir_i = 1'b0; rslv_tar_i = 64'h0;
    tick();
    rslv_vld_i = 1'b0;
    checks++;
    if (brcond_vld_rt_o !== 1'b0 || dut.count_r !== 5'd12) begin
      $display("FAIL same_cyc got vld=%b cnt=%0d exp vld=0 cnt=12", brcond_vld_rt_o, dut.count_r); failures++;
    end
    tick();
    commit_br_i = 1'b0;
    checks++;
    if (brcond_vld_rt_o !== 1'b1 || brpc_rt_o !== 64'h8400 || dut.count_r !== 5'd11) begin
      $display("FAIL late_ret got vld=%b pc=%h cnt=%0d exp vld=1 pc=8400 cnt=11", brcond_vld_rt_o, brpc_rt_o, dut.count_r);
      failures++;
    end
  endtask

  task automatic test_flush_alloc();
    do_resolve(4'd11, 1'b1, 64'h7777_0000);
    commit_br_i = 1'b1;
    alloc_vld_i = 1'b1; alloc_brpc_i = 64'hDEAD; alloc_brtyp_i = 2'b01; alloc_ptar_i = 64'h0;
    tick();
    commit_br_i = 1'b0; alloc_vld_i = 1'b0;
    checks++;
    if (flush_o !== 1'b1 || redirect_pc_o !== 64'h7777_0000 || brpc_rt_o !== 64'h8500) begin
      $display("FAIL fa_flush got flush=%b redir=%h pc=%h exp flush=1 redir=77770000 pc=8500", flush_o, redirect_pc_o, brpc_rt_o);
      failures++;
    end
    checks++;
    if (dut.count_r !== 5'd0 || alloc_tag_o !== 4'd12 || alloc_rdy_o !== 1'b1) begin
      $display("FAIL fa_empty got cnt=%0d tag=%0d rdy=%b exp cnt=0 tag=12 rdy=1", dut.count_r, alloc_tag_o, alloc_rdy_o);
      failures++;
    end
    do_commit();
    checks++;
    if ({brcond_vld_rt_o, brindir_vld_rt_o, flush_o} !== 3'b000) begin
      $display("FAIL fa_nocommit got=%b exp=000", {brcond_vld_rt_o, brindir_vld_rt_o, flush_o}); failures++;
    end
  endtask

  task automatic test_reset_mid();
    do_alloc(64'hC000, 2'b01, 1'b1, 64'hC100);
    commit_br_i = 1'b1; reset = 1'b1;
    tick();
    commit_br_i = 1'b0; reset = 1'b0;
    checks++;
    if ({brcond_vld_rt_o, brindir_vld_rt_o, brdir_rt_o, flush_o} !== 4'b0000 ||
        {brtar_rt_o, brpc_rt_o, redirect_pc_o} !== 192'd0) begin
      $display("FAIL rmid_out got flags=%b pc=%h tar=%h redir=%h exp all 0",
               {brcond_vld_rt_o, brindir_vld_rt_o, brdir_rt_o, flush_o}, brpc_rt_o, brtar_rt_o, redirect_pc_o);
      failures++;
    end
    checks++;
    if (alloc_rdy_o !== 1'b1 || alloc_tag_o !== 4'd0 || dut.count_r !== 5'd0) begin
      $display("FAIL rmid_state got rdy=%b tag=%0d cnt=%0d exp rdy=1 tag=0 cnt=0", alloc_rdy_o, alloc_tag_o, dut.count_r);
      failures++;
    end
  endtask

  initial begin
    reset = 1'b1;
    alloc_vld_i = 1'b0; alloc_brpc_i = 64'h0; alloc_brtyp_i = 2'b00;
    alloc_pdir_i = 1'b0; alloc_ptar_i = 64'h0;
    rslv_vld_i = 1'b0; rslv_tag_i = 4'd0; rslv_dir_i = 1'b0; rslv_tar_i = 64'h0;
    commit_br_i = 1'b0;
    test_reset();
    test_cond_correct();
    test_cond_mispred();
    test_indirect();
    test_direct();
    test_fill();
    test_unresolved();
    test_flush_alloc();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
